// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: shared FSM state type and gate-counter sizing for clk_freq_meter
package clk_meas_pkg;
  typedef enum logic [1:0] {IDLE, ARM, GATE, REPORT} meas_state_t;
  function automatic int gate_cnt_w(input int gate_cycles);
    return $clog2(gate_cycles);
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer followed by a registered rising-edge pulse
module sync_edge_detect (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_meta, d_sync, d_prev;
  // resynchronise d, keep its previous value and flag each 0->1 transition
  always_ff @(posedge clk_100mhz or negedge rst_n)
    if (!rst_n) begin
      d_meta <= 1'b0;
      d_sync <= 1'b0;
      d_prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      d_meta <= d;
      d_sync <= d_meta;
      d_prev <= d_sync;
      rise <= d_sync & ~d_prev;
    end
endmodule

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts sig_in rising edges per gate window and flags range and lock
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int GATE_CYCLES    = 1000,
  parameter int EXPECTED_EDGES = 100,
  parameter int TOLERANCE      = 2,
  parameter int LOCK_WINDOWS   = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             in_range,
  output logic             locked,
  output logic             no_signal
);
  localparam int GW = gate_cnt_w(GATE_CYCLES);
  localparam int LW = $clog2(LOCK_WINDOWS + 1);
  localparam int EW = $clog2(EXPECTED_EDGES + 1);
  localparam int DW = (CNT_W > EW ? CNT_W : EW) + 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  meas_state_t state;
  logic rise;
  logic [GW-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_nxt;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic signed [DW-1:0] diff;
  logic [DW-1:0] diff_abs;
  logic range_ok;
  sync_edge_detect u_sync (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .d          (sig_in),
    .rise       (rise)
  );
  assign edge_nxt = (rise && edge_cnt != CNT_MAX) ? edge_cnt + 1'b1 : edge_cnt;
  assign diff = $signed(DW'(edge_nxt)) - $signed(DW'(EXPECTED_EDGES));
  assign diff_abs = diff < 0 ? -diff : diff;
  assign range_ok = diff_abs <= DW'(TOLERANCE);
  assign lock_nxt = !range_ok ? '0 : lock_cnt == LOCK_MAX ? lock_cnt : lock_cnt + 1'b1;
  // measurement FSM: arm, count over the gate, publish results on entry to REPORT
  always_ff @(posedge clk_100mhz or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      lock_cnt <= '0;
      edge_count <= '0;
      count_valid <= 1'b0;
      in_range <= 1'b0;
      locked <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          state <= enable ? ARM : IDLE;
        end
        ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          state <= enable ? GATE : IDLE;
          if (!enable) begin
            lock_cnt <= '0;
            locked <= 1'b0;
          end
        end
        GATE: begin
          if (!enable) begin
            state <= IDLE;
            lock_cnt <= '0;
            locked <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_nxt;
            if (gate_cnt == GATE_LAST) begin
              state <= REPORT;
              edge_count <= edge_nxt;
              count_valid <= 1'b1;
              in_range <= range_ok;
              no_signal <= edge_nxt == '0;
              lock_cnt <= lock_nxt;
              locked <= lock_nxt == LOCK_MAX;
            end
          end
        end
        REPORT: begin
          edge_cnt <= CNT_W'(rise);
          gate_cnt <= '0;
          state <= enable ? GATE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: randomized edge-count stimulus checked against a window-level reference model
`timescale 1ns/100ps
module tb_clk_freq_meter;
  localparam int G = 1000;
  localparam int E = 100;
  localparam int T = 2;
  localparam int L = 4;
  logic clk_100mhz = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic sig_in = 1'b0;
  logic [15:0] edge_count;
  logic count_valid, in_range, locked, no_signal;
  logic [5:0] edge_count6;
  logic count_valid6, in_range6, locked6, no_signal6;
  int n_chk = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  bit sig_on = 1'b1;
  real half_ns = 50.0;
  bit h [4];
  bit m_run, m_arm;
  int m_left, m_acc, m_lock, m_lock6;
  int exp_cnt, exp_cnt6;
  bit exp_valid, exp_in, exp_in6, exp_ns, exp_locked, exp_locked6;

  clk_freq_meter u_dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .enable      (enable),
    .sig_in      (sig_in),
    .edge_count  (edge_count),
    .count_valid (count_valid),
    .in_range    (in_range),
    .locked      (locked),
    .no_signal   (no_signal)
  );

  clk_freq_meter #(.CNT_W(6)) u_dut6 (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .enable      (enable),
    .sig_in      (sig_in),
    .edge_count  (edge_count6),
    .count_valid (count_valid6),
    .in_range    (in_range6),
    .locked      (locked6),
    .no_signal   (no_signal6)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #0.3;
    forever begin
      sig_in = sig_on ? ~sig_in : 1'b0;
      #(half_ns);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    h = '{default: 1'b0};
    m_run = 0;
    m_arm = 0;
    m_left = 0;
    m_acc = 0;
    m_lock = 0;
    m_lock6 = 0;
    exp_cnt = 0;
    exp_cnt6 = 0;
    exp_valid = 0;
    exp_in = 0;
    exp_in6 = 0;
    exp_ns = 0;
    exp_locked = 0;
    exp_locked6 = 0;
  endtask

  task automatic model_abort();
    m_run = 0;
    m_arm = 0;
    m_lock = 0;
    m_lock6 = 0;
    exp_locked = 0;
    exp_locked6 = 0;
  endtask

  function automatic bit near(input int c);
    return (c > E ? c - E : E - c) <= T;
  endfunction

  task automatic model_report();
    exp_cnt = m_acc > 65535 ? 65535 : m_acc;
    exp_cnt6 = m_acc > 63 ? 63 : m_acc;
    exp_in = near(exp_cnt);
    exp_in6 = near(exp_cnt6);
    exp_ns = m_acc == 0;
    m_lock = exp_in ? (m_lock < L ? m_lock + 1 : L) : 0;
    m_lock6 = exp_in6 ? (m_lock6 < L ? m_lock6 + 1 : L) : 0;
    exp_locked = m_lock == L;
    exp_locked6 = m_lock6 == L;
    exp_valid = 1;
  endtask

  // an edge sampled at clock k is counted by the meter at clock k+3
  task automatic model_step();
    bit r;
    r = h[2] & ~h[3];
    h[3] = h[2];
    h[2] = h[1];
    h[1] = h[0];
    h[0] = sig_in;
    exp_valid = 0;
    if (!m_run) begin
      m_run = enable;
      m_arm = enable;
    end else if (m_arm) begin
      if (!enable) model_abort();
      else begin
        m_arm = 0;
        m_acc = 0;
        m_left = G;
      end
    end else if (m_left == 0) begin
      m_acc = int'(r);
      m_left = G;
      m_run = enable;
    end else if (!enable) model_abort();
    else begin
      m_acc += int'(r);
      m_left--;
      if (m_left == 0) model_report();
    end
  endtask

  initial forever begin
    @(posedge clk_100mhz or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk_100mhz);
    if (rst_n && chk_on) begin
      chk("count_valid", count_valid, exp_valid);
      chk("edge_count", edge_count, exp_cnt);
      chk("in_range", in_range, exp_in);
      chk("no_signal", no_signal, exp_ns);
      chk("locked", locked, exp_locked);
      chk("count_valid6", count_valid6, exp_valid);
      chk("edge_count6", edge_count6, exp_cnt6);
      chk("in_range6", in_range6, exp_in6);
      chk("locked6", locked6, exp_locked6);
    end
  end

  task automatic run_windows(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < n * (G + 2) + G + 10) begin
      @(negedge clk_100mhz);
      cyc++;
      if (count_valid) seen++;
    end
    chk("windows_seen", seen, n);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_edge_count"}, edge_count, 0);
    chk({tag, "_count_valid"}, count_valid, 0);
    chk({tag, "_in_range"}, in_range, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_no_signal"}, no_signal, 0);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    check_zero("rst");
    rst_n = 1'b1;
    chk_on = 1'b1;
    enable = 1'b1;
    run_windows(6);
    chk("lock_10m", locked, 1);
    chk("in_range_10m", in_range, 1);
    chk("sat_count6", edge_count6, 63);
    chk("sat_in_range6", in_range6, 0);
    half_ns = 51.5;
    run_windows(5);
    chk("slow_in_range", in_range, 0);
    chk("slow_locked", locked, 0);
    half_ns = 50.0;
    run_windows(5);
    chk("relock", locked, 1);
    half_ns = 51.5;
    run_windows(2);
    chk("unlock_again", locked, 0);
    sig_on = 1'b0;
    run_windows(2);
    chk("zero_count", edge_count, 0);
    chk("zero_no_signal", no_signal, 1);
    chk("zero_in_range", in_range, 0);
    sig_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      half_ns = real'($urandom_range(48, 52)) + 0.5 * real'($urandom_range(0, 1));
      run_windows(1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_100mhz);
      enable = 1'b0;
      repeat ($urandom_range(2, 5)) @(negedge clk_100mhz);
      enable = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk_100mhz);
    end
    half_ns = 50.0;
    run_windows(5);
    chk("lock_before_abort", locked, 1);
    repeat (500) @(negedge clk_100mhz);
    enable = 1'b0;
    n = 0;
    repeat (600) begin
      @(negedge clk_100mhz);
      if (count_valid) n++;
    end
    chk("abort_no_valid", n, 0);
    chk("abort_locked", locked, 0);
    enable = 1'b1;
    n = 0;
    while (n < 3 * G) begin
      @(negedge clk_100mhz);
      n++;
      if (count_valid) break;
    end
    chk("first_valid_latency", n, G + 2);
    run_windows(1);
    enable = 1'b0;
    repeat (20) @(negedge clk_100mhz);
    chk("report_then_idle_locked", locked, exp_locked);
    enable = 1'b1;
    run_windows(5);
    chk("lock_before_reset", locked, 1);
    repeat (300) @(negedge clk_100mhz);
    @(posedge clk_100mhz);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    chk("midrst_edge_count6", edge_count6, 0);
    repeat (3) @(negedge clk_100mhz);
    rst_n = 1'b1;
    run_windows(5);
    chk("lock_after_reset", locked, 1);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
